// File: rtl/l2_req_responder.sv
// l2_req_responder
//   Single-outstanding LLC-side responder for the Spandex L2 request channel.
//   Accepts one l2_req_out message at a time, waits LATENCY extra cycles and
//   returns the matching l2_rsp_in message. A direct-mapped line store (no tag)
//   keeps write-through / writeback data so later reads return it.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   l2_req_out_valid/ready   request handshake (ready is registered)
//   l2_req_out_*             request fields: coh_msg, hprot, addr, line, word_mask
//   l2_rsp_in_valid/ready    response handshake (valid is registered)
//   l2_rsp_in_*              response fields: coh_msg, addr, line, word_mask, invack_cnt
//   req_cnt                  accepted-request count, saturating
//   err                      sticky flag for unsupported coh_msg codes
module l2_req_responder #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LATENCY = 2,
  localparam int unsigned COH_W   = 5,
  localparam int unsigned HPROT_W = 2,
  localparam int unsigned ADDR_W  = 28,
  localparam int unsigned WORDS   = 4,
  localparam int unsigned WORD_W  = 32,
  localparam int unsigned LINE_W  = WORDS * WORD_W,
  localparam int unsigned INV_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               l2_req_out_valid,
  output logic               l2_req_out_ready,
  input  logic [COH_W-1:0]   l2_req_out_coh_msg,
  input  logic [HPROT_W-1:0] l2_req_out_hprot,
  input  logic [ADDR_W-1:0]  l2_req_out_addr,
  input  logic [LINE_W-1:0]  l2_req_out_line,
  input  logic [WORDS-1:0]   l2_req_out_word_mask,
  output logic               l2_rsp_in_valid,
  input  logic               l2_rsp_in_ready,
  output logic [COH_W-1:0]   l2_rsp_in_coh_msg,
  output logic [ADDR_W-1:0]  l2_rsp_in_addr,
  output logic [LINE_W-1:0]  l2_rsp_in_line,
  output logic [WORDS-1:0]   l2_rsp_in_word_mask,
  output logic [INV_W-1:0]   l2_rsp_in_invack_cnt,
  output logic [15:0]        req_cnt,
  output logic               err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Spandex request / response message codes
  localparam logic [COH_W-1:0] REQ_V      = 5'd0;
  localparam logic [COH_W-1:0] REQ_S      = 5'd1;
  localparam logic [COH_W-1:0] REQ_WT     = 5'd2;
  localparam logic [COH_W-1:0] REQ_O      = 5'd3;
  localparam logic [COH_W-1:0] REQ_WB     = 5'd4;
  localparam logic [COH_W-1:0] REQ_Odata  = 5'd5;
  localparam logic [COH_W-1:0] RSP_V      = 5'd0;
  localparam logic [COH_W-1:0] RSP_S      = 5'd1;
  localparam logic [COH_W-1:0] RSP_O      = 5'd3;
  localparam logic [COH_W-1:0] RSP_WB_ACK = 5'd4;
  localparam logic [COH_W-1:0] RSP_Odata  = 5'd5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  state_t              state_q;
  logic                ready_q;
  logic [7:0]          cnt_q;
  logic [15:0]         req_cnt_q;
  logic [15:0]         req_cnt_d;
  logic                err_q;
  logic                rsp_valid_q;
  logic [COH_W-1:0]    rsp_msg_q;
  logic [ADDR_W-1:0]   rsp_addr_q;
  logic [LINE_W-1:0]   rsp_line_q;
  logic [WORDS-1:0]    rsp_mask_q;
  logic [COH_W-1:0]    cap_msg_q;
  logic [ADDR_W-1:0]   cap_addr_q;
  logic [LINE_W-1:0]   cap_line_q;
  logic [WORDS-1:0]    cap_mask_q;
  logic [LINE_W-1:0]   store_q [DEPTH];
  logic                accept;
  logic [IDX_W-1:0]    in_idx;
  logic [IDX_W-1:0]    cap_idx;
  logic                unused_hprot;

  function automatic logic is_write(input logic [COH_W-1:0] m);
    return (m == REQ_WT) || (m == REQ_WB);
  endfunction

  function automatic logic is_supported(input logic [COH_W-1:0] m);
    return (m == REQ_V) || (m == REQ_S) || (m == REQ_O) || (m == REQ_Odata) ||
           (m == REQ_WT) || (m == REQ_WB);
  endfunction

  function automatic logic [COH_W-1:0] rsp_msg_for(input logic [COH_W-1:0] m);
    logic [COH_W-1:0] r;
    case (m)
      REQ_S:     r = RSP_S;
      REQ_O:     r = RSP_O;
      REQ_Odata: r = RSP_Odata;
      REQ_WT:    r = RSP_O;
      REQ_WB:    r = RSP_WB_ACK;
      default:   r = RSP_V;
    endcase
    return r;
  endfunction

  // Overwrite only the words whose mask bit is set.
  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] old_l,
                                                   input logic [LINE_W-1:0] new_l,
                                                   input logic [WORDS-1:0]  m);
    logic [LINE_W-1:0] r;
    r = old_l;
    for (int w = 0; w < int'(WORDS); w++) begin
      if (m[w]) r[w*WORD_W +: WORD_W] = new_l[w*WORD_W +: WORD_W];
    end
    return r;
  endfunction

  assign unused_hprot = ^l2_req_out_hprot;
  assign accept       = l2_req_out_valid && ready_q && (state_q == S_IDLE);
  assign in_idx       = l2_req_out_addr[IDX_W-1:0];
  assign cap_idx      = cap_addr_q[IDX_W-1:0];
  assign req_cnt_d    = (req_cnt_q == 16'hFFFF) ? req_cnt_q : req_cnt_q + 16'd1;

  // Control FSM with registered handshake and response outputs. ready_q resets
  // high so the gated output is high in the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      req_cnt_q   <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_msg_q   <= '0;
      rsp_addr_q  <= '0;
      rsp_line_q  <= '0;
      rsp_mask_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!ready_q) begin
            // one dead cycle after an unsupported message
            ready_q <= 1'b1;
          end else if (l2_req_out_valid) begin
            ready_q   <= 1'b0;
            req_cnt_q <= req_cnt_d;
            cnt_q     <= 8'(LATENCY);
            if (is_supported(l2_req_out_coh_msg)) state_q <= S_WAIT;
            else                                  err_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            // read data sampled here so it reflects every earlier write
            state_q     <= S_SEND;
            rsp_valid_q <= 1'b1;
            rsp_msg_q   <= rsp_msg_for(cap_msg_q);
            rsp_addr_q  <= cap_addr_q;
            if (cap_msg_q == REQ_WT)      rsp_line_q <= cap_line_q;
            else if (cap_msg_q == REQ_WB) rsp_line_q <= '0;
            else                          rsp_line_q <= store_q[cap_idx];
            if ((cap_msg_q == REQ_S) || (cap_msg_q == REQ_O)) rsp_mask_q <= '1;
            else                                              rsp_mask_q <= cap_mask_q;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_SEND: begin
          if (l2_rsp_in_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line store: writes merge at the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) store_q[i] <= '0;
    end else if (accept && is_write(l2_req_out_coh_msg)) begin
      store_q[in_idx] <= merge_line(store_q[in_idx], l2_req_out_line, l2_req_out_word_mask);
    end
  end

  // Request capture (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_msg_q  <= l2_req_out_coh_msg;
      cap_addr_q <= l2_req_out_addr;
      cap_line_q <= l2_req_out_line;
      cap_mask_q <= l2_req_out_word_mask;
    end
  end

  assign l2_req_out_ready     = ready_q && (state_q == S_IDLE) && rst;
  assign l2_rsp_in_valid      = rsp_valid_q;
  assign l2_rsp_in_coh_msg    = rsp_msg_q;
  assign l2_rsp_in_addr       = rsp_addr_q;
  assign l2_rsp_in_line       = rsp_line_q;
  assign l2_rsp_in_word_mask  = rsp_mask_q;
  assign l2_rsp_in_invack_cnt = '0;
  assign req_cnt              = req_cnt_q;
  assign err                  = err_q;

endmodule

// File: doc/l2_req_responder.md
# l2_req_responder

Single-outstanding LLC-side responder for the Spandex L2 request channel: consumes `l2_req_out` messages issued by the L2 and returns matching `l2_rsp_in` messages. It holds a small direct-mapped line store, so read data reflects earlier write-throughs and writebacks. It sits in the L2 unit-level bench and in LLC-less bring-up configurations in place of the NoC/LLC path.

## Interface
- `DEPTH`, 16: line-store entries (power of two); index = low `$clog2(DEPTH)` bits of line address.
- `LATENCY`, 2: extra wait cycles between accept and response valid (0–255).
- `clk` input 1: clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `l2_req_out_valid` input 1: request valid from L2.
- `l2_req_out_ready` output 1: responder can accept.
- `l2_req_out` input `l2_req_out_t.in`: fields coh_msg, hprot, addr, line, word_mask.
- `l2_rsp_in_valid` output 1: response valid to L2.
- `l2_rsp_in_ready` input 1: L2 accepts response.
- `l2_rsp_in` output `l2_rsp_in_t.out`: fields coh_msg, addr, line, word_mask, invack_cnt.
- `req_cnt` output 16: accepted-request count, saturating at 16'hFFFF.
- `err` output 1: sticky, set on unsupported coh_msg.

## Operation
- FSM states IDLE, WAIT, SEND; reset → IDLE.
- IDLE: `l2_req_out_ready`=1. On valid&ready, capture addr, coh_msg, word_mask, line; load wait counter with `LATENCY`; increment `req_cnt`; go WAIT.
- Per request type (constants from spandex_consts.svh):
  - `REQ_V`, `REQ_S`, `REQ_O`, `REQ_Odata`: response `RSP_V`/`RSP_S`/`RSP_O`/`RSP_Odata`; line = store[index]; word_mask = captured mask (`REQ_S` and `REQ_O` return all-ones mask).
  - `REQ_WT`: store words with mask bit set are overwritten at the accept edge; response `RSP_O` with line = captured line and mask = captured mask.
  - `REQ_WB`: same merge as `REQ_WT`; response `RSP_WB_ACK`, line = 0.
  - Any other code: accepted and counted, no response, `err`←1, FSM returns to IDLE next cycle (skips WAIT/SEND).
- WAIT: if counter = 0 go SEND, else decrement.
- SEND: `l2_rsp_in_valid`=1. Response fields are registered and held stable until the handshake. Response addr = captured line address; invack_cnt = 0. On `l2_rsp_in_ready`, go IDLE.
- Read data is sampled when SEND is entered. It therefore includes all prior writes to that index, aliases included (tag is not checked).
- `err` clears only on reset.

## Timing
- Reset values: `l2_req_out_ready`=0 while `rst`=0, and 1 in the first cycle after deassertion. `l2_rsp_in_valid`=0; all `l2_rsp_in` fields 0; `req_cnt`=0; `err`=0; all store lines 0.
- Accept at edge E0 → `l2_rsp_in_valid` rises after edge E0+LATENCY+1. For `LATENCY`=0, valid is high in the cycle right after the accept cycle.
- `l2_req_out_ready` is low from E0 until the response handshake edge. It is high again the following cycle; no same-cycle accept on the response handshake.
- No combinational path from `l2_rsp_in_ready` or `l2_req_out_valid` to any output.
- Backpressure: valid held with stable data any number of cycles while ready=0.
- Reset asserted mid-transaction: FSM → IDLE, pending response dropped, valid low immediately (async).
- `req_cnt` holds at 16'hFFFF when saturated. Unsupported messages are counted.

## Test plan
- Reset, then `REQ_V` to addr 0x40 with mask 0x1 → `RSP_V` with line 0, mask 0x1, invack_cnt 0; valid exactly LATENCY+1 cycles after accept; `req_cnt`=1.
- `REQ_WT` to line address 0x3 with mask 0x2 and word1 = 0xDEADBEEF, then `REQ_S` to the same line → `RSP_O` ack first. Then `RSP_S` with word1 = 0xDEADBEEF, other words 0, and mask all-ones.
- `REQ_WB` full line 0xA5 pattern, then `REQ_V` to an alias index (addr + DEPTH lines) → `RSP_WB_ACK` with line 0, then `RSP_V` returning the 0xA5 pattern.
- Hold `l2_rsp_in_ready`=0 for 10 cycles during SEND → valid and all fields stable; `l2_req_out_ready`=0 throughout; one response only after ready rises.
- Unsupported coh_msg → no response, `err`=1 and sticky, `l2_req_out_ready` high again 2 cycles after accept; `req_cnt` increments.
- Assert `rst` during WAIT → valid stays 0, `req_cnt`=0, store cleared. A following `REQ_V` returns line 0.
